pio_seg7_display: RTL



---
 rtl/pio_seg7_display.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pio_seg7_display.sv
// Shows the PIO output word in decimal on a multiplexed common-anode 7-segment display.
// A serial double-dabble FSM converts to BCD, and a prescaled scanner drives the digits with leading-zero blanking.
module pio_seg7_display #(
    parameter int DATA_W     = 8,
    parameter int NUM_DIGITS = 3,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       in_value,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    busy,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(DATA_W + 1);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [NUM_DIGITS-1:0] AN_RST  = (ACTIVE_LOW != 0) ? ~NUM_DIGITS'(1) : NUM_DIGITS'(1);
    localparam logic [6:0]            SEG_RST = (ACTIVE_LOW != 0) ? 7'b1000000 : 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     in_q, in_d;
    logic [DATA_W-1:0]     last_val_q, last_val_d;
    logic [DATA_W-1:0]     cap_q, cap_d;
    logic [DATA_W-1:0]     bin_q, bin_d;
    logic [BW-1:0]         acc_q, acc_d;
    logic [BW-1:0]         bcd_q, bcd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [DW-1:0]         idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic [BW-1:0]         adj;
    logic [3:0]            digit;
    logic                  blank;
    logic [6:0]            seg_hi;
    logic [NUM_DIGITS-1:0] an_hot;

    // Active-high glyphs {g,f,e,d,c,b,a}; codes 10-15 light nothing.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        in_d       = in_value;
        state_d    = state_q;
        last_val_d = last_val_q;
        cap_d      = cap_q;
        bin_d      = bin_q;
        acc_d      = acc_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        adj        = acc_q;

        case (state_q)
            IDLE: begin
                if (in_q != last_val_q) begin
                    bin_d   = in_q;
                    cap_d   = in_q;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
                end
                acc_d = {adj[BW-2:0], bin_q[DATA_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_W - 1)) state_d = DONE;
            end
            DONE: begin
                bcd_d      = acc_q;
                last_val_d = cap_q;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        presc_d = (presc_q == PW'(SCAN_DIV - 1)) ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            idx_d = (idx_q == DW'(NUM_DIGITS - 1)) ? '0 : idx_q + DW'(1);
        end

        digit  = '0;
        blank  = 1'b0;
        an_hot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == DW'(i)) begin
                digit     = bcd_q[4*i +: 4];
                // Leading zero: this digit and every higher one are zero.
                blank     = (i != 0) && ((bcd_q >> (4*i)) == '0);
                an_hot[i] = 1'b1;
            end
        end
        seg_hi = blank ? 7'h00 : glyph(digit);
        seg_d  = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
        an_d   = (ACTIVE_LOW != 0) ? ~an_hot : an_hot;
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            in_q       <= '0;
            last_val_q <= '0;
            cap_q      <= '0;
            bin_q      <= '0;
            acc_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_RST;
            an_q       <= AN_RST;
        end else begin
            state_q    <= state_d;
            in_q       <= in_d;
            last_val_q <= last_val_d;
            cap_q      <= cap_d;
            bin_q      <= bin_d;
            acc_q      <= acc_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign bcd_out = bcd_q;
    assign busy    = busy_q;
    assign seg     = seg_q;
    assign an      = an_q;

endmodule
